wb_copy_master: RTL and testbench

WB_COPY_MASTER -- requirements
Module: wb_copy_master

---
 rtl/wb_copy_master_if.sv | 15 +
 rtl/wb_copy_master.sv | 115 +++++++++++
 tb/tb_wb_copy_master.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/wb_copy_master_if.sv
// Classic Wishbone initiator/target signal bundle used by wb_copy_master.
interface wb_copy_master_if #(
  parameter int AW = 10
);
  logic          cyc_o;
  logic          stb_o;
  logic          we_o;
  logic [AW-1:0] adr_o;
  logic [31:0]   dat_o;
  logic [31:0]   dat_i;
  logic          ack_i;

  modport master (output cyc_o, stb_o, we_o, adr_o, dat_o, input dat_i, ack_i);
  modport slave  (input cyc_o, stb_o, we_o, adr_o, dat_o, output dat_i, ack_i);
endinterface

// File: rtl/wb_copy_master.sv
// Word-by-word memory copy engine: alternating classic Wishbone read and write
// cycles, with a per-access ack timeout that aborts the copy and flags err.
module wb_copy_master #(
  parameter int AW  = 10,
  parameter int LW  = 10,
  parameter int TMO = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [AW-1:0]         src_adr,
  input  logic [AW-1:0]         dst_adr,
  input  logic [LW-1:0]         len,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  wb_copy_master_if.master      wb
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  localparam logic [7:0] TMO_CNT = 8'(TMO);

  state_t        state_q, state_d;
  logic [AW-1:0] src_q, dst_q;
  logic [LW-1:0] len_q, idx_q;
  logic [31:0]   buf_q;
  logic [7:0]    wcnt_q;
  logic          err_q;

  logic load, latch, step, abort;

  // NOTE: every signal driven here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    latch   = 1'b0;
    step    = 1'b0;
    abort   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = (len != '0) ? READ : DONE;
        end
      end
      READ: begin
        if (wb.ack_i) begin
          latch   = 1'b1;
          state_d = WRITE;
        end else if (wcnt_q == TMO_CNT) begin
          abort   = 1'b1;
          state_d = DONE;
        end
      end
      WRITE: begin
        if (wb.ack_i) begin
          step    = 1'b1;
          state_d = (idx_q + LW'(1) == len_q) ? DONE : READ;
        end else if (wcnt_q == TMO_CNT) begin
          abort   = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      buf_q   <= '0;
      wcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) begin
        src_q <= src_adr;
        dst_q <= dst_adr;
        len_q <= len;
        idx_q <= '0;
        err_q <= 1'b0;
      end
      if (latch) buf_q <= wb.dat_i;
      if (step)  idx_q <= idx_q + LW'(1);
      if (abort) err_q <= 1'b1;
      // Waits are counted per access: restart on any state change or ack.
      if (state_d != state_q || wb.ack_i) wcnt_q <= '0;
      else if (busy)                      wcnt_q <= wcnt_q + 8'd1;
    end
  end

  assign busy     = (state_q == READ) || (state_q == WRITE);
  assign done     = (state_q == DONE);
  assign err      = err_q;
  assign wb.cyc_o = busy;
  assign wb.stb_o = busy;
  assign wb.we_o  = (state_q == WRITE);
  assign wb.dat_o = buf_q;

  always_comb begin
    wb.adr_o = '0;
    if (state_q == READ)       wb.adr_o = src_q + AW'(idx_q);
    else if (state_q == WRITE) wb.adr_o = dst_q + AW'(idx_q);
  end

endmodule

// File: tb/tb_wb_copy_master.sv
// Directed bench for wb_copy_master: a memory slave with configurable wait
// states and a scoreboard of expected bus accesses popped on every ack.
module tb_wb_copy_master;
  localparam int AW  = 10;
  localparam int LW  = 10;
  localparam int TMO = 255;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] src_adr = '0;
  logic [AW-1:0] dst_adr = '0;
  logic [LW-1:0] len = '0;
  logic          busy, done, err;

  wb_copy_master_if #(.AW(AW)) wb ();

  wb_copy_master #(.AW(AW), .LW(LW), .TMO(TMO)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .src_adr (src_adr),
    .dst_adr (dst_adr),
    .len     (len),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .wb      (wb.master)
  );

  always #5 clk = ~clk;

  // Slave memory; ack is combinational once `waits` wait cycles have elapsed.
  logic [31:0] mem [0:1023];
  int          waits = 0;
  bit          never = 1'b0;
  logic [7:0]  scnt = '0;

  assign wb.ack_i = wb.cyc_o & wb.stb_o & ~never & (int'(scnt) == waits);
  assign wb.dat_i = mem[wb.adr_o];

  always @(posedge clk) begin
    if (wb.cyc_o && wb.stb_o && !wb.ack_i) scnt <= scnt + 8'd1;
    else                                   scnt <= '0;
    if (wb.ack_i && wb.we_o) mem[wb.adr_o] <= wb.dat_o;
  end

  typedef struct {
    logic          we;
    logic [AW-1:0] adr;
    logic [31:0]   dat;
  } acc_t;

  acc_t exp_q[$];
  acc_t mon_e;
  int   total = 0;
  int   bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Monitor: pops the scoreboard on each acked access, and checks that the
  // bus holds still across wait cycles.
  logic [AW+34:0] prev_bus = '0;
  logic [AW+34:0] cur_bus;
  bit             prev_wait = 1'b0;

  always @(negedge clk) begin
    cur_bus = {wb.cyc_o, wb.stb_o, wb.we_o, wb.adr_o, wb.dat_o};
    if (!rst && prev_wait && wb.cyc_o) check("wait_stable", 64'(cur_bus), 64'(prev_bus));
    if (!rst && wb.cyc_o && wb.ack_i) begin
      check("scoreboard_has_entry", 64'(exp_q.size() != 0), 64'(1));
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("acc_we", 64'(wb.we_o), 64'(mon_e.we));
        check("acc_adr", 64'(wb.adr_o), 64'(mon_e.adr));
        if (mon_e.we) check("acc_wdat", 64'(wb.dat_o), 64'(mon_e.dat));
        else          check("acc_rdat", 64'(wb.dat_i), 64'(mon_e.dat));
      end
    end
    prev_wait = !rst && wb.cyc_o && !wb.ack_i;
    prev_bus  = cur_bus;
  end

  // Fill source words and queue the expected read/write pairs in order.
  task automatic prep(input logic [AW-1:0] s, input logic [AW-1:0] d,
                      input int n, input logic [31:0] base);
    logic [AW-1:0] sa, da;
    for (int k = 0; k < n; k++) begin
      sa = s + AW'(k);
      da = d + AW'(k);
      mem[sa] = base + 32'(k);
      exp_q.push_back('{we: 1'b0, adr: sa, dat: base + 32'(k)});
      exp_q.push_back('{we: 1'b1, adr: da, dat: base + 32'(k)});
    end
  endtask

  task automatic check_mem(input string tag, input logic [AW-1:0] d,
                           input int n, input logic [31:0] base);
    logic [AW-1:0] da;
    for (int k = 0; k < n; k++) begin
      da = d + AW'(k);
      check(tag, 64'(mem[da]), 64'(base + 32'(k)));
    end
  endtask

  // Pulse start, then count busy/cyc/done cycles; c=0 is the first cycle
  // after start is accepted. A stray start is driven at cycle stray_at.
  task automatic run_copy(input logic [AW-1:0] s, input logic [AW-1:0] d,
                          input logic [LW-1:0] n, input int budget, input int stray_at,
                          output int busy_n, output int done_n, output int cyc_n,
                          output int done_at);
    busy_n = 0; done_n = 0; cyc_n = 0; done_at = -1;
    @(posedge clk); #1;
    src_adr = s; dst_adr = d; len = n; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (busy)     busy_n++;
      if (wb.cyc_o) cyc_n++;
      if (done) begin
        done_n++;
        if (done_at < 0) done_at = c;
      end
      if (c == stray_at) begin
        start = 1'b1; src_adr = 10'h155; dst_adr = 10'h2AA; len = 10'd7;
      end else if (c == stray_at + 1) begin
        start = 1'b0;
      end
      if (done_at >= 0 && c >= done_at + 3) break;
    end
    check("done_within_budget", 64'(done_at >= 0), 64'(1));
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b_n, d_n, c_n, d_at;
    for (int k = 0; k < 1024; k++) mem[k] = '0;

    // Reset state
    #2 rst = 1'b1;
    #3;
    check("reset_outputs", 64'({wb.cyc_o, wb.stb_o, wb.we_o, wb.adr_o, wb.dat_o, busy, done, err}), 64'(0));
    @(negedge clk);
    rst = 1'b0;

    // Zero-wait copy of four words: 2 cycles per word
    prep(10'h010, 10'h200, 4, 32'hA000_0000);
    run_copy(10'h010, 10'h200, 10'd4, 60, -1, b_n, d_n, c_n, d_at);
    check("a_busy_cycles", 64'(b_n), 64'(8));
    check("a_cyc_cycles", 64'(c_n), 64'(8));
    check("a_done_pulses", 64'(d_n), 64'(1));
    check("a_done_at", 64'(d_at), 64'(8));
    check("a_err", 64'(err), 64'(0));
    check_mem("a_mem", 10'h200, 4, 32'hA000_0000);

    // Same copy with three wait states per access
    for (int k = 0; k < 4; k++) mem[10'h200 + k] = '0;
    waits = 3;
    prep(10'h010, 10'h200, 4, 32'hA000_0000);
    run_copy(10'h010, 10'h200, 10'd4, 80, -1, b_n, d_n, c_n, d_at);
    check("b_busy_cycles", 64'(b_n), 64'(32));
    check("b_done_pulses", 64'(d_n), 64'(1));
    check("b_err", 64'(err), 64'(0));
    check_mem("b_mem", 10'h200, 4, 32'hA000_0000);
    waits = 0;

    // Source address wraps 0x3FF -> 0x000; scoreboard enforces the order
    prep(10'h3FE, 10'h100, 3, 32'h5EED_0000);
    run_copy(10'h3FE, 10'h100, 10'd3, 40, -1, b_n, d_n, c_n, d_at);
    check("d_busy_cycles", 64'(b_n), 64'(6));
    check_mem("d_mem", 10'h100, 3, 32'h5EED_0000);

    // Slave never acks: TMO wait cycles are tolerated, the next unacked
    // cycle aborts, so cyc_o is high for TMO+1 cycles
    never = 1'b1;
    run_copy(10'h020, 10'h300, 10'd2, 300, -1, b_n, d_n, c_n, d_at);
    check("e_cyc_cycles", 64'(c_n), 64'(TMO + 1));
    check("e_done_pulses", 64'(d_n), 64'(1));
    check("e_err", 64'(err), 64'(1));
    repeat (5) @(negedge clk);
    check("e_err_held", 64'(err), 64'(1));
    never = 1'b0;

    // len=0: no bus cycle, done right after the accepting cycle, err cleared
    run_copy(10'h030, 10'h330, 10'd0, 10, -1, b_n, d_n, c_n, d_at);
    check("c_cyc_cycles", 64'(c_n), 64'(0));
    check("c_done_at", 64'(d_at), 64'(0));
    check("c_done_pulses", 64'(d_n), 64'(1));
    check("c_err", 64'(err), 64'(0));

    // Reset during the second WRITE of a four-word copy
    prep(10'h040, 10'h240, 4, 32'hBEEF_0000);
    @(posedge clk); #1;
    src_adr = 10'h040; dst_adr = 10'h240; len = 10'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("f_in_second_write", 64'({busy, wb.we_o}), 64'(2'b11));
    #2 rst = 1'b1;
    #1;
    check("f_reset_outputs", 64'({wb.cyc_o, wb.stb_o, wb.we_o, wb.adr_o, wb.dat_o, busy, done, err}), 64'(0));
    check("f_pending_after_abort", 64'(exp_q.size()), 64'(4));
    exp_q.delete();
    repeat (2) begin
      @(negedge clk);
      check("f_no_done_in_reset", 64'(done), 64'(0));
    end
    rst = 1'b0;

    // Fresh copy after reset, with a stray start while busy
    prep(10'h010, 10'h280, 4, 32'hC0DE_0000);
    run_copy(10'h010, 10'h280, 10'd4, 60, 2, b_n, d_n, c_n, d_at);
    check("g_busy_cycles", 64'(b_n), 64'(8));
    check("g_done_pulses", 64'(d_n), 64'(1));
    check_mem("g_mem", 10'h280, 4, 32'hC0DE_0000);
    check("g_stray_dst_untouched", 64'(mem[10'h2AA]), 64'(0));

    check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
